spike_train_generator: RTL and testbench

- Multi-channel, parametrised successor to the single-channel temporal spike comparator.
- Owns its own gamma-cycle time counter and double-buffers one spike-time vector per gamma wave.
- Drives NUM_CH spike lines, in step (race-logic level) or single-pulse mode.
- Sits between the input encoder and the first column/neuron layer of the temporal network.

---
 rtl/spike_train_generator.sv | 110 +++++++++++
 tb/tb_spike_train_generator.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/spike_train_generator.sv
// spike_train_generator: multi-channel gamma-wave spike generator with double-buffered spike times.
// Optional SPIKE_COUNT_EN adds spike_count, the number of channels that fired in the last wave.
module spike_train_generator #(
    parameter int NUM_CH     = 8,
    parameter int TIME_W     = 4,
    parameter int GAMMA_LEN  = 16,
    parameter int PULSE_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [NUM_CH*TIME_W-1:0] load_times,
    input  logic [NUM_CH-1:0]        load_inhibit,
    input  logic                     start,
    output logic                     busy,
    output logic [TIME_W-1:0]        time_val,
    output logic [NUM_CH-1:0]        spike_out,
    output logic                     gamma_done
`ifdef SPIKE_COUNT_EN
    ,
    output logic [$clog2(NUM_CH+1)-1:0] spike_count
`endif
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [TIME_W:0]   G_LEN     = (TIME_W+1)'(GAMMA_LEN);
    localparam logic [TIME_W-1:0] LAST_SLOT = TIME_W'(GAMMA_LEN - 1);
    state_t                     state, state_nxt;
    logic                       shadow_valid, last, copy, accept;
    logic [NUM_CH*TIME_W-1:0]   shadow_t, act_t, act_t_nxt;
    logic [NUM_CH-1:0]          shadow_inh, act_inh, act_inh_nxt, spike_nxt;
    logic [TIME_W-1:0]          time_nxt;

    function automatic logic [NUM_CH-1:0] spikes(input logic [NUM_CH*TIME_W-1:0] t,
                                                 input logic [NUM_CH-1:0] inh,
                                                 input logic [TIME_W-1:0] tv);
        logic [NUM_CH-1:0] s;
        logic [TIME_W-1:0] ti;
        s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ti = t[i*TIME_W +: TIME_W];
            s[i] = !inh[i] && ({1'b0, ti} < G_LEN) && ((PULSE_MODE != 0) ? (tv == ti) : (tv >= ti));
        end
        return s;
    endfunction

    assign load_ready = !shadow_valid;
    assign busy       = (state == RUN);

    // A load accepted this cycle lands in the shadow after the copy decision, so it cannot feed it.
    always_comb begin
        accept      = load_valid && !shadow_valid;
        last        = (state == RUN) && (time_val == LAST_SLOT);
        copy        = shadow_valid && (((state == IDLE) && start) || last);
        state_nxt   = copy ? RUN : (last ? IDLE : state);
        time_nxt    = ((state == RUN) && !last) ? time_val + TIME_W'(1) : '0;
        act_t_nxt   = copy ? shadow_t : act_t;
        act_inh_nxt = copy ? shadow_inh : act_inh;
        spike_nxt   = (state_nxt == RUN) ? spikes(act_t_nxt, act_inh_nxt, time_nxt) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shadow_valid <= 1'b0;
            shadow_t     <= '0;
            shadow_inh   <= '0;
            act_t        <= '0;
            act_inh      <= '0;
            time_val     <= '0;
            spike_out    <= '0;
            gamma_done   <= 1'b0;
        end else begin
            state        <= state_nxt;
            shadow_valid <= accept || (shadow_valid && !copy);
            if (accept) begin
                shadow_t   <= load_times;
                shadow_inh <= load_inhibit;
            end
            act_t        <= act_t_nxt;
            act_inh      <= act_inh_nxt;
            time_val     <= time_nxt;
            spike_out    <= spike_nxt;
            gamma_done   <= last;
        end
    end

`ifdef SPIKE_COUNT_EN
    localparam int CW = $clog2(NUM_CH + 1);
    logic [NUM_CH-1:0] seen, seen_all;
    logic [CW-1:0]     cnt;

    // seen_all folds in the final slot's spikes, which are still only in spike_out.
    always_comb begin
        seen_all = seen | spike_out;
        cnt = '0;
        for (int i = 0; i < NUM_CH; i++) cnt = cnt + CW'(seen_all[i]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seen        <= '0;
            spike_count <= '0;
        end else begin
            seen        <= last ? '0 : seen_all;
            spike_count <= last ? cnt : spike_count;
        end
    end
`endif
endmodule

// File: tb/tb_spike_train_generator.sv
// tb_spike_train_generator: step and pulse instances driven in lockstep against a wave-level reference model.
module tb_spike_train_generator;
    localparam int NC = 8, TW = 5, GL = 16, CW = $clog2(NC + 1);
    logic clk = 0, rst = 1, load_valid = 0, start = 0;
    logic [NC*TW-1:0] load_times = '0;
    logic [NC-1:0] load_inhibit = '0;
    logic ready_s, busy_s, done_s, ready_p, busy_p, done_p;
    logic [TW-1:0] time_s, time_p;
    logic [NC-1:0] spike_s, spike_p;
`ifdef SPIKE_COUNT_EN
    logic [CW-1:0] count_s, count_p;
`endif
    int n_chk = 0, n_pass = 0;
    bit m_run, m_full, m_done;
    int m_slot, m_count, wave_cnt;
    int sh_t[NC], act_t[NC];
    logic [NC-1:0] sh_inh, act_inh;
    int vec_a[NC] = '{0, 3, 15, 16, 7, 7, 1, 2};

    always #5 clk = ~clk;

    spike_train_generator #(.NUM_CH(NC), .TIME_W(TW), .GAMMA_LEN(GL), .PULSE_MODE(0)) u_step (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_s), .load_times(load_times),
        .load_inhibit(load_inhibit), .start(start), .busy(busy_s), .time_val(time_s),
        .spike_out(spike_s), .gamma_done(done_s)
`ifdef SPIKE_COUNT_EN
        , .spike_count(count_s)
`endif
    );

    spike_train_generator #(.NUM_CH(NC), .TIME_W(TW), .GAMMA_LEN(GL), .PULSE_MODE(1)) u_pulse (
        .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(ready_p), .load_times(load_times),
        .load_inhibit(load_inhibit), .start(start), .busy(busy_p), .time_val(time_p),
        .spike_out(spike_p), .gamma_done(done_p)
`ifdef SPIKE_COUNT_EN
        , .spike_count(count_p)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [NC*TW-1:0] pack(input int a[NC]);
        logic [NC*TW-1:0] v;
        for (int i = 0; i < NC; i++) v[i*TW +: TW] = TW'(a[i]);
        return v;
    endfunction

    function automatic logic [NC*TW-1:0] rand_times();
        logic [NC*TW-1:0] v;
        for (int i = 0; i < NC; i++) v[i*TW +: TW] = TW'($urandom_range(0, 20));
        return v;
    endfunction

    // Every non-inhibited channel with a reachable time fires exactly once (pulse) or from t on (step).
    function automatic logic [NC-1:0] exp_spikes(input bit pulse);
        logic [NC-1:0] e;
        for (int i = 0; i < NC; i++)
            e[i] = m_run && !act_inh[i] && act_t[i] < GL && (pulse ? m_slot == act_t[i] : m_slot >= act_t[i]);
        return e;
    endfunction

    function automatic int enabled_count();
        int c = 0;
        for (int i = 0; i < NC; i++) if (!act_inh[i] && act_t[i] < GL) c++;
        return c;
    endfunction

    task automatic start_wave();
        act_t = sh_t;
        act_inh = sh_inh;
        m_full = 0;
        m_run = 1;
        m_slot = 0;
        wave_cnt = enabled_count();
    endtask

    task automatic model_step();
        bit accept;
        if (rst) begin
            m_run = 0; m_full = 0; m_done = 0; m_slot = 0; m_count = 0;
            for (int i = 0; i < NC; i++) act_t[i] = 0;
            act_inh = '0;
            return;
        end
        accept = load_valid && !m_full;
        m_done = m_run && m_slot == GL - 1;
        if (!m_run) begin
            if (start && m_full) start_wave();
        end else if (m_done) begin
            m_count = wave_cnt;
            if (m_full) start_wave();
            else begin
                m_run = 0;
                m_slot = 0;
            end
        end else m_slot++;
        if (accept) begin
            for (int i = 0; i < NC; i++) sh_t[i] = int'(load_times[i*TW +: TW]);
            sh_inh = load_inhibit;
            m_full = 1;
        end
    endtask

    task automatic compare();
        check("busy_s", 64'(busy_s), 64'(m_run));
        check("time_s", 64'(time_s), 64'(m_slot));
        check("spike_s", 64'(spike_s), 64'(exp_spikes(0)));
        check("done_s", 64'(done_s), 64'(m_done));
        check("ready_s", 64'(ready_s), 64'(!m_full));
        check("busy_p", 64'(busy_p), 64'(m_run));
        check("time_p", 64'(time_p), 64'(m_slot));
        check("spike_p", 64'(spike_p), 64'(exp_spikes(1)));
        check("done_p", 64'(done_p), 64'(m_done));
        check("ready_p", 64'(ready_p), 64'(!m_full));
`ifdef SPIKE_COUNT_EN
        check("count_s", 64'(count_s), 64'(m_count));
        check("count_p", 64'(count_p), 64'(m_count));
`endif
    endtask

    task automatic cyc(input bit lv, input logic [NC*TW-1:0] t, input logic [NC-1:0] inh, input bit st, input bit r);
        load_valid = lv;
        load_times = t;
        load_inhibit = inh;
        start = st;
        rst = r;
        @(posedge clk);
        model_step();
        #1;
        compare();
    endtask

    initial begin
        logic [NC*TW-1:0] va, vb;
        va = pack(vec_a);
        vb = rand_times();
        cyc(0, '0, '0, 0, 1);
        cyc(0, '0, '0, 0, 1);
        cyc(1, va, 8'h20, 0, 0);
        cyc(0, va, 8'h20, 0, 0);
        cyc(0, va, 8'h20, 1, 0);
        repeat (20) cyc(0, va, 8'h20, 0, 0);
        repeat (2) cyc(0, va, 8'h20, 1, 0);
        cyc(1, va, 8'h20, 0, 0);
        cyc(0, va, 8'h20, 1, 0);
        repeat (5) cyc(0, va, 8'h20, 0, 0);
        repeat (25) cyc(1, vb, 8'h03, 0, 0);
        repeat (40) cyc(0, vb, 8'h03, 0, 0);
        cyc(1, va, 8'h00, 0, 0);
        cyc(0, va, 8'h00, 1, 0);
        cyc(1, vb, 8'h00, 0, 0);
        repeat (5) cyc(0, vb, 8'h00, 0, 0);
        cyc(0, vb, 8'h00, 0, 1);
        repeat (3) cyc(0, vb, 8'h00, 1, 0);
        repeat (3000)
            cyc($urandom_range(0, 3) == 0, rand_times(), NC'($urandom_range(0, 255) & $urandom_range(0, 255)),
                $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
